// File: rtl/bi_to_gr_code_pkg.sv
// Shared Gray-code definitions: default width and width-generic encode/decode
// helpers so pointer logic elsewhere can reuse the same mapping.
package bi_to_gr_code_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 64;

  typedef logic [MAX_WIDTH-1:0] word_t;

  // Callers zero-extend narrower words; unused upper bits then stay zero.
  function automatic word_t bin2gray(input word_t v);
    return v ^ (v >> 1);
  endfunction

  function automatic word_t gray2bin(input word_t v);
    word_t r;
    r[MAX_WIDTH-1] = v[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      r[i] = r[i+1] ^ v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bi_to_gr_code_gray2bin_chain.sv
// Combinational Gray-to-binary decode: prefix XOR running from the MSB down.
module gray2bin_chain
  import bi_to_gr_code_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin : chain
    logic acc;
    bin             = '0;
    acc             = gray[WIDTH-1];
    bin[WIDTH-1]    = acc;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      acc    = acc ^ gray[i];
      bin[i] = acc;
    end
  end

endmodule

// File: rtl/bi_to_gr_code.sv
// Binary-to-Gray converter with optional Gray-to-binary decode and a single
// registered output stage (1-cycle latency, 1 word per cycle).
module bi_to_gr_code
  import bi_to_gr_code_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             dec,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] g,
  output logic             out_valid
);

  // Handshake: in_valid qualifies b/dec in the same cycle; there is no ready,
  // every valid word is taken, and out_valid marks g for exactly the following
  // cycle. With in_valid low, g keeps its last result.

  logic [WIDTH-1:0] enc;
  logic [WIDTH-1:0] dcd;
  logic [WIDTH-1:0] result;

  always_comb begin
    enc          = '0;
    enc[WIDTH-1] = b[WIDTH-1];
    for (int i = 0; i < WIDTH - 1; i++) begin
      enc[i] = b[i+1] ^ b[i];
    end
  end

  gray2bin_chain #(.WIDTH(WIDTH)) u_decode (
    .gray (b),
    .bin  (dcd)
  );

  assign result = dec ? dcd : enc;

  always_ff @(posedge clk) begin
    if (rst) begin
      g         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        g <= result;
      end
    end
  end

endmodule

// File: tb/tb_bi_to_gr_code.sv
// Directed bench: vector table for encode sweep and decode spot checks, plus
// reset, valid-gap and round-trip sequences at WIDTH=4 and WIDTH=8.
module tb_bi_to_gr_code;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, dec;
  logic [3:0] b, g;
  logic       out_valid;
  logic       in_valid8, dec8;
  logic [7:0] b8, g8;
  logic       out_valid8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bi_to_gr_code #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .dec(dec), .b(b),
    .g(g), .out_valid(out_valid)
  );

  bi_to_gr_code #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .dec(dec8), .b(b8),
    .g(g8), .out_valid(out_valid8)
  );

  typedef struct {
    logic       dec;
    logic [3:0] b;
    logic [3:0] exp_g;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one word at the negedge, sample the result just after the next posedge.
  task automatic step(input logic r, input logic v, input logic d, input logic [3:0] w);
    @(negedge clk);
    rst = r; in_valid = v; dec = d; b = w;
    @(posedge clk);
    #1;
  endtask

  task automatic step8(input logic v, input logic d, input logic [7:0] w);
    @(negedge clk);
    in_valid8 = v; dec8 = d; b8 = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] gray_tab[16];
    logic [3:0] prev;
    logic [7:0] enc8;

    gray_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    for (int i = 0; i < 16; i++) vecs[i] = '{1'b0, 4'(i), gray_tab[i]};
    vecs[16] = '{1'b1, 4'b1000, 4'b1111};
    vecs[17] = '{1'b1, 4'b0010, 4'b0011};
    vecs[18] = '{1'b1, 4'b1100, 4'b1000};

    rst = 1'b1; in_valid = 1'b1; dec = 1'b0; b = 4'b1111;
    in_valid8 = 1'b0; dec8 = 1'b0; b8 = '0;

    // Reset dominates a simultaneous valid word.
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 1'b1, 1'b0, 4'b1111);
      check("reset_g", 8'(g), 8'h00);
      check("reset_ov", 8'(out_valid), 8'h00);
    end

    // Back-to-back table vectors: encode sweep then decode spot checks.
    prev = 4'b1000;
    for (int i = 0; i < 19; i++) begin
      step(1'b0, 1'b1, vecs[i].dec, vecs[i].b);
      check($sformatf("vec%0d_g", i), 8'(g), 8'(vecs[i].exp_g));
      check($sformatf("vec%0d_ov", i), 8'(out_valid), 8'h01);
      if (i < 16) begin
        check($sformatf("vec%0d_1bit", i), 8'($countones(g ^ prev)), 8'h01);
        prev = g;
      end
    end

    // Valid gap: result holds while b wanders, out_valid pulses once.
    step(1'b0, 1'b1, 1'b0, 4'b0101);
    check("gap_load_g", 8'(g), 8'h07);
    check("gap_load_ov", 8'(out_valid), 8'h01);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, 1'(c), 4'($urandom_range(0, 15)));
      check("gap_hold_g", 8'(g), 8'h07);
      check("gap_hold_ov", 8'(out_valid), 8'h00);
    end

    // Reset in the middle of a stream, then resume.
    step(1'b0, 1'b1, 1'b0, 4'b0110);
    check("mid_pre_g", 8'(g), 8'h05);
    step(1'b1, 1'b1, 1'b0, 4'b0011);
    check("mid_rst_g", 8'(g), 8'h00);
    check("mid_rst_ov", 8'(out_valid), 8'h00);
    step(1'b0, 1'b1, 1'b0, 4'b0010);
    check("mid_resume_g", 8'(g), 8'h03);
    check("mid_resume_ov", 8'(out_valid), 8'h01);
    step(1'b0, 1'b1, 1'b1, 4'b0011);
    check("mid_resume_dec_g", 8'(g), 8'h02);

    // 4-bit round trip with mode switching every cycle.
    for (int v = 0; v < 16; v++) begin
      step(1'b0, 1'b1, 1'b0, 4'(v));
      check($sformatf("rt4_enc%0d", v), 8'(g), 8'(gray_tab[v]));
      step(1'b0, 1'b1, 1'b1, g);
      check($sformatf("rt4_dec%0d", v), 8'(g), 8'(v));
    end
    step(1'b0, 1'b0, 1'b0, 4'b0000);

    // 8-bit round trip over every value.
    for (int v = 0; v < 256; v++) begin
      step8(1'b1, 1'b0, 8'(v));
      enc8 = 8'(v) ^ (8'(v) >> 1);
      check($sformatf("rt8_enc%0d", v), g8, enc8);
      step8(1'b1, 1'b1, g8);
      check($sformatf("rt8_dec%0d", v), g8, 8'(v));
      check("rt8_ov", 8'(out_valid8), 8'h01);
    end
    step8(1'b0, 1'b0, 8'hff);
    check("rt8_idle_ov", 8'(out_valid8), 8'h00);
    step8(1'b1, 1'b0, 8'hff);
    check("rt8_ones_enc", g8, 8'h80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
